// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared state encoding, job sizes and bus-slice offsets for the conv tile sequencer
package conv_seq_pkg;
    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;
    localparam int FILTER_N = 9;
    localparam int TILE_N = 16;
    localparam int RESULT_N = 4;
    localparam int LOAD_LAST = 24;
    function automatic int filter_off(input int idx, input int w);
        return idx * w;
    endfunction
    function automatic int input_off(input int idx, input int w);
        return idx * w;
    endfunction
    function automatic int result_off(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/conv_tile_sequencer_if.sv
// conv_tile_sequencer_if: byte streams in/out plus the parallel array buses
interface conv_tile_sequencer_if #(parameter int DATA_W = 8);
    import conv_seq_pkg::*;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            in_data;
    logic                         arr_rst;
    logic [TILE_N*DATA_W-1:0]     arr_input;
    logic [FILTER_N*DATA_W-1:0]   arr_filter;
    logic [RESULT_N*DATA_W-1:0]   arr_result;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            out_data;
    logic                         out_last;
    logic                         busy;
    modport master (
        input  in_valid, in_data, arr_result, out_ready,
        output in_ready, arr_rst, arr_input, arr_filter, out_valid, out_data, out_last, busy
    );
    modport slave (
        output in_valid, in_data, arr_result, out_ready,
        input  in_ready, arr_rst, arr_input, arr_filter, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/conv_result_serializer.sv
// conv_result_serializer: captures the four array results and drains them as a valid/ready byte stream
module conv_result_serializer
    import conv_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cap,
    input  logic [RESULT_N*DATA_W-1:0] i_result,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_last,
    output logic                       o_done
);
    logic [DATA_W-1:0] r_res [RESULT_N];
    logic [DATA_W-1:0] w_cap [RESULT_N];
    logic [1:0]        r_idx;
    logic [1:0]        w_nxt;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              w_fire;

    for (genvar k = 0; k < RESULT_N; k++) begin : g_cap
        assign w_cap[k] = i_result[result_off(k, DATA_W) +: DATA_W];
    end

    assign w_fire = r_valid && i_ready;
    assign w_nxt = r_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res   <= '{default: '0};
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_cap) begin
            r_res   <= w_cap;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= w_cap[0];
            r_last  <= 1'b0;
        end else if (w_fire) begin
            r_idx   <= w_nxt;
            r_valid <= !r_last;
            r_data  <= r_last ? '0 : r_res[w_nxt];
            r_last  <= w_nxt == 2'(RESULT_N - 1);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_done  = w_fire && r_last;
endmodule

// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer: loads filter+tile bytes, runs the 2x2 systolic array for a fixed window,
// then streams the four results back out
module conv_tile_sequencer
    import conv_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COMPUTE_CYCLES = 24
) (
    input logic clk,
    input logic rst,
    conv_tile_sequencer_if.master bus
);
    localparam int CW = COMPUTE_CYCLES > 1 ? $clog2(COMPUTE_CYCLES) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_idx;
    logic [3:0]        w_tidx;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_f [FILTER_N];
    logic [DATA_W-1:0] r_t [TILE_N];
    logic              r_in_ready;
    logic              r_arr_rst;
    logic              r_busy;
    logic              w_in_ready;
    logic              w_arr_rst;
    logic              w_busy;
    logic              w_take;
    logic              w_run_end;
    logic              w_done;

    assign w_take    = r_in_ready && bus.in_valid;
    assign w_run_end = r_state == RUN && r_cnt == CW'(COMPUTE_CYCLES - 1);
    assign w_tidx    = 4'(r_idx - 5'(FILTER_N));

    always_comb begin
        w_next = (w_take && r_idx == 5'(LOAD_LAST)) ? RUN :
                 w_run_end ? DRAIN :
                 (r_state == DRAIN && w_done) ? LOAD : r_state;
    end

    // outputs are registered, so they are derived from the state being entered
    always_comb begin
        w_in_ready = w_next == LOAD;
        w_arr_rst  = w_next != RUN;
        w_busy     = w_next != LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_arr_rst  <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_take ? (r_idx == 5'(LOAD_LAST) ? '0 : r_idx + 5'd1) : r_idx;
            r_cnt      <= (r_state == RUN && !w_run_end) ? r_cnt + 1'b1 : '0;
            r_in_ready <= w_in_ready;
            r_arr_rst  <= w_arr_rst;
            r_busy     <= w_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f <= '{default: '0};
            r_t <= '{default: '0};
        end else if (w_take) begin
            if (r_idx < 5'(FILTER_N))
                r_f[r_idx[3:0]] <= bus.in_data;
            else
                r_t[w_tidx] <= bus.in_data;
        end
    end

    for (genvar k = 0; k < FILTER_N; k++) begin : g_flt
        assign bus.arr_filter[filter_off(k, DATA_W) +: DATA_W] = r_f[k];
    end
    for (genvar k = 0; k < TILE_N; k++) begin : g_inp
        assign bus.arr_input[input_off(k, DATA_W) +: DATA_W] = r_t[k];
    end

    assign bus.in_ready = r_in_ready;
    assign bus.arr_rst  = r_arr_rst;
    assign bus.busy     = r_busy;

    conv_result_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .i_cap    (w_run_end),
        .i_result (bus.arr_result),
        .i_ready  (bus.out_ready),
        .o_valid  (bus.out_valid),
        .o_data   (bus.out_data),
        .o_last   (bus.out_last),
        .o_done   (w_done)
    );
endmodule

// File: tb/tb_conv_tile_sequencer.sv
// tb_conv_tile_sequencer: random and directed jobs against a stub 2x2 array and a convolution reference
module tb_conv_tile_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       use_conv = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'd0;
    int errors = 0;
    int checks = 0;

    conv_tile_sequencer_if #(.DATA_W(8)) bus_a ();
    conv_tile_sequencer_if #(.DATA_W(8)) bus_b ();

    conv_tile_sequencer #(.DATA_W(8), .COMPUTE_CYCLES(24)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    conv_tile_sequencer #(.DATA_W(8), .COMPUTE_CYCLES(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    function automatic logic [31:0] conv(input logic [7:0] f[9], input logic [7:0] t[16]);
        logic [31:0] r = '0;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
                int s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += int'(f[i*3+j]) * int'(t[(a+i)*4+b+j]);
                r = r | (32'(s[7:0]) << (8 * (a*2 + b)));
            end
        return r;
    endfunction

    // stand-in array: result is only meaningful on the last cycle of its compute window
    function automatic logic [31:0] arr_model(input logic [127:0] inp, input logic [71:0] flt, input logic uc);
        logic [7:0] f[9];
        logic [7:0] t[16];
        for (int k = 0; k < 9; k++) f[k] = flt[k*8 +: 8];
        for (int k = 0; k < 16; k++) t[k] = inp[k*8 +: 8];
        return uc ? conv(f, t) : 32'h44332211;
    endfunction

    logic [7:0] lo_a = 8'd0;
    logic [7:0] lo_b = 8'd0;
    always @(posedge clk) begin
        lo_a <= bus_a.arr_rst ? 8'd0 : lo_a + 8'd1;
        lo_b <= bus_b.arr_rst ? 8'd0 : lo_b + 8'd1;
    end

    assign bus_a.in_valid   = in_valid & ~sel;
    assign bus_b.in_valid   = in_valid & sel;
    assign bus_a.in_data    = in_data;
    assign bus_b.in_data    = in_data;
    assign bus_a.out_ready  = out_ready & ~sel;
    assign bus_b.out_ready  = out_ready & sel;
    assign bus_a.arr_result = (!bus_a.arr_rst && lo_a == 8'd23) ?
                              arr_model(bus_a.arr_input, bus_a.arr_filter, use_conv) : 32'hA5A5A5A5;
    assign bus_b.arr_result = (!bus_b.arr_rst && lo_b == 8'd0) ?
                              arr_model(bus_b.arr_input, bus_b.arr_filter, use_conv) : 32'hA5A5A5A5;

    logic         w_in_ready, w_arr_rst, w_out_valid, w_out_last, w_busy;
    logic [7:0]   w_out_data;
    logic [127:0] w_arr_input;
    logic [71:0]  w_arr_filter;
    assign w_in_ready   = sel ? bus_b.in_ready   : bus_a.in_ready;
    assign w_arr_rst    = sel ? bus_b.arr_rst    : bus_a.arr_rst;
    assign w_out_valid  = sel ? bus_b.out_valid  : bus_a.out_valid;
    assign w_out_last   = sel ? bus_b.out_last   : bus_a.out_last;
    assign w_busy       = sel ? bus_b.busy       : bus_a.busy;
    assign w_out_data   = sel ? bus_b.out_data   : bus_a.out_data;
    assign w_arr_input  = sel ? bus_b.arr_input  : bus_a.arr_input;
    assign w_arr_filter = sel ? bus_b.arr_filter : bus_a.arr_filter;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] b[25], input int gap_mode);
        int i = 0;
        int t = 0;
        logic acc;
        while (i < 25 && t < 500) begin
            in_valid = gap_mode == 0 ? 1'b1 : gap_mode == 1 ? (t % 2 == 0) : ($urandom_range(0, 2) != 0);
            in_data = b[i];
            acc = in_valid && w_in_ready;
            @(negedge clk);
            t++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        check("load_count", 128'(i), 128'd25);
    endtask

    task automatic run_job(input logic [7:0] b[25], input int gap_mode, input int bp_mode);
        int cc = sel ? 1 : 24;
        int n = 0;
        int k = 0;
        int t = 0;
        logic [7:0] f[9];
        logic [7:0] tl[16];
        logic [71:0] ef;
        logic [127:0] ei;
        logic [31:0] er;
        for (int j = 0; j < 9; j++) begin f[j] = b[j]; ef[j*8 +: 8] = b[j]; end
        for (int j = 0; j < 16; j++) begin tl[j] = b[9+j]; ei[j*8 +: 8] = b[9+j]; end
        er = use_conv ? conv(f, tl) : 32'h44332211;
        load(b, gap_mode);
        check("run_arr_rst", 128'(w_arr_rst), 128'd0);
        check("run_in_ready", 128'(w_in_ready), 128'd0);
        check("run_busy", 128'(w_busy), 128'd1);
        check("filter_bus", 128'(w_arr_filter), 128'(ef));
        check("input_bus", w_arr_input, ei);
        while (!w_arr_rst && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("rst_low_cycles", 128'(n), 128'(cc));
        check("drain_valid", 128'(w_out_valid), 128'd1);
        check("drain_busy", 128'(w_busy), 128'd1);
        check("hold_input_bus", w_arr_input, ei);
        while (k < 4 && t < 500) begin
            out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? (t >= 10) : 1'($urandom_range(0, 1));
            if (bp_mode == 1 && t == 9) begin
                check("stall_data", 128'(w_out_data), 128'(er[7:0]));
                check("stall_valid", 128'(w_out_valid), 128'd1);
                check("stall_in_ready", 128'(w_in_ready), 128'd0);
            end
            if (w_out_valid && out_ready) begin
                check($sformatf("byte%0d", k), 128'(w_out_data), 128'(er[k*8 +: 8]));
                check($sformatf("last%0d", k), 128'(w_out_last), 128'(k == 3));
                k++;
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        check("drain_count", 128'(k), 128'd4);
        check("end_valid", 128'(w_out_valid), 128'd0);
        check("end_in_ready", 128'(w_in_ready), 128'd1);
        check("end_busy", 128'(w_busy), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] basic[25] = '{8'd1, 8'd5, 8'd3, 8'd4, 8'd0, 8'd10, 8'd0, 8'd7, 8'd15,
                                  8'd10, 8'd5, 8'd1, 8'd4, 8'd6, 8'd0, 8'd12, 8'd15,
                                  8'd3, 8'd8, 8'd0, 8'd9, 8'd11, 8'd16, 8'd25, 8'd7};
        logic [7:0] rb[25];
        int seen;
        repeat (3) @(negedge clk);
        check("rst_arr_rst", 128'(w_arr_rst), 128'd1);
        check("rst_in_ready", 128'(w_in_ready), 128'd0);
        check("rst_out_valid", 128'(w_out_valid), 128'd0);
        check("rst_out_last", 128'(w_out_last), 128'd0);
        check("rst_out_data", 128'(w_out_data), 128'd0);
        check("rst_busy", 128'(w_busy), 128'd0);
        check("rst_input", w_arr_input, 128'd0);
        check("rst_filter", 128'(w_arr_filter), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 128'(w_in_ready), 128'd1);

        use_conv = 1'b0;
        run_job(basic, 0, 0);
        use_conv = 1'b1;
        run_job(basic, 0, 0);
        run_job(basic, 1, 0);
        run_job(basic, 0, 1);

        for (int j = 0; j < 25; j++) rb[j] = 8'($urandom);
        load(rb, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_arr_rst", 128'(w_arr_rst), 128'd1);
        check("midrst_input", w_arr_input, 128'd0);
        check("midrst_filter", 128'(w_arr_filter), 128'd0);
        check("midrst_busy", 128'(w_busy), 128'd0);
        @(negedge clk);
        check("midrst_in_ready", 128'(w_in_ready), 128'd1);
        seen = 0;
        repeat (40) begin
            if (w_out_valid) seen++;
            @(negedge clk);
        end
        check("no_partial_out", 128'(seen), 128'd0);
        for (int j = 0; j < 25; j++) rb[j] = 8'($urandom);
        run_job(rb, 0, 0);

        sel = 1'b1;
        @(negedge clk);
        repeat (2) begin
            for (int j = 0; j < 25; j++) rb[j] = 8'($urandom);
            run_job(rb, 0, 0);
        end
        sel = 1'b0;
        @(negedge clk);

        repeat (6) begin
            for (int j = 0; j < 25; j++) rb[j] = 8'($urandom);
            run_job(rb, 2, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
